// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants and types for the serial program loader.
//   SYNC_BYTE     frame start marker
//   ldr_state_t   frame-level loader FSM states
//   rx_state_t    UART byte receiver FSM states
//   dbg_t         both FSM states, exported from the top for observation
//   ERR_*         values reported on err_code
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ldr_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        ldr_state_t ldr;
        rx_state_t  rx;
    } dbg_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_CSUM    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_FRAME   = 3'd4;
    localparam logic [2:0] ERR_PARITY  = 3'd5;

endpackage

// File: rtl/prog_loader_uart_rx_byte.sv
// uart_rx_byte: UART byte receiver, 8N1 by default, 8E1 when
// PROG_LOADER_PARITY_EN is defined.
//   clk, rst     system clock, asynchronous active-high reset
//   rx           raw serial line, idle high, asynchronous to clk
//   byte_valid   one-cycle pulse, one cycle after a good stop-bit sample
//   byte_data    received byte, valid with byte_valid (holds afterwards)
//   frame_err    one-cycle pulse when the stop bit is sampled low
//   parity_err   one-cycle pulse on an even-parity mismatch (parity builds only)
//   state_dbg    current receiver FSM state
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       parity_err,
    output rx_state_t  state_dbg
);

    localparam int            CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;
`ifdef PROG_LOADER_PARITY_EN
    logic          par_q, par_d;
`endif

    // Synchronizer plus one extra stage for falling-edge detection.
    // All three reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // State register (bit-timing datapath registered alongside).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
`ifdef PROG_LOADER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
`ifdef PROG_LOADER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef PROG_LOADER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_sync) state_d = RX_START;
            end
            RX_START: begin
                // Mid-start-bit re-check; a high line here was a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    sh_d  = {rx_sync, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef PROG_LOADER_PARITY_EN
                        state_d = RX_PAR;
`else
                        state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef PROG_LOADER_PARITY_EN
            RX_PAR: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = rx_sync;
                    state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    // A bad stop bit takes precedence over a parity mismatch.
                    if (!rx_sync) begin
                        ferr_d = 1'b1;
`ifdef PROG_LOADER_PARITY_EN
                    end else if (par_q != ^sh_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b1;
                        data_d  = sh_q;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        byte_valid = valid_q;
        byte_data  = data_q;
        frame_err  = ferr_q;
        parity_err = perr_q;
        state_dbg  = state_q;
    end

endmodule

// File: rtl/prog_loader_uart.sv
// prog_loader_uart: loads a framed program image (A5, LEN, LEN payload bytes,
// CSUM = payload sum mod 256) from a UART line into instruction memory and
// releases the core only after a complete, checksum-correct frame.
// Optional feature: PROG_LOADER_PARITY_EN selects 8E1 framing (err code 5).
//   clk, rst   system clock, asynchronous active-high reset
//   rx         UART receive line, idle high
//   mem_we     one-cycle write strobe; mem_addr/mem_data stable with it and held
//   cpu_run    1 = core may execute; dropped when a SYNC starts a new frame
//   busy       1 while a frame is in progress (LEN, DATA, CSUM)
//   done       one-cycle pulse on a successful load
//   err_code   sticky status (prog_loader_pkg ERR_*), cleared by the next SYNC
//   dbg        loader and receiver FSM states
//
// Handshake: the receiver presents byte_valid for exactly one cycle with
// byte_data stable in that cycle; there is no backpressure, so the loader
// consumes every byte in the cycle it is offered.
module prog_loader_uart
    import prog_loader_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int ADDR_W  = 5,
    parameter int MAX_LEN = 19,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err_code,
    output dbg_t              dbg
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    logic       byte_valid, frame_err, parity_err;
    logic [7:0] byte_data;
    rx_state_t  rx_state;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .state_dbg  (rx_state)
    );

    ldr_state_t        state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TW-1:0]     to_q, to_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [7:0]        mdata_q, mdata_d;
    logic              run_q, run_d;
    logic              done_q, done_d;
    logic [2:0]        err_q, err_d;

    logic       is_sync, len_ok, last_byte, rx_err, to_expire;
    logic [2:0] cause;

    always_comb begin
        is_sync   = (byte_data == SYNC_BYTE);
        len_ok    = (byte_data != 8'd0) && (byte_data <= MAX_LEN_B);
        last_byte = (8'(addr_q) == len_q - 8'd1);
        rx_err    = frame_err | parity_err;
        // A byte arriving in the expiry cycle wins over the timeout.
        to_expire = !byte_valid && (to_q == TO_LAST);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (byte_valid && is_sync) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (byte_valid)               state_d = len_ok ? ST_DATA : ST_ERR;
                else if (rx_err || to_expire) state_d = ST_ERR;
            end
            ST_DATA: begin
                if (byte_valid) begin
                    if (last_byte) state_d = ST_CSUM;
                end else if (rx_err || to_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_CSUM: begin
                if (byte_valid)               state_d = (byte_data == sum_q) ? ST_DONE : ST_ERR;
                else if (rx_err || to_expire) state_d = ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reason for an entry into ERR; only meaningful on that transition.
    always_comb begin
        if (byte_valid)      cause = (state_q == ST_LEN) ? ERR_LEN : ERR_CSUM;
        else if (frame_err)  cause = ERR_FRAME;
        else if (parity_err) cause = ERR_PARITY;
        else                 cause = ERR_TIMEOUT;
    end

    // Output / datapath logic, keyed on the transition being taken.
    always_comb begin
        len_d   = len_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        to_d    = '0;
        we_d    = 1'b0;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        run_d   = run_q;
        done_d  = 1'b0;
        err_d   = err_q;

        if (state_q == ST_LEN || state_q == ST_DATA || state_q == ST_CSUM)
            to_d = byte_valid ? '0 : to_q + TW'(1);

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (state_d == ST_LEN) begin
                    err_d = ERR_NONE;
                    run_d = 1'b0;
                end
            end
            ST_LEN: begin
                if (state_d == ST_DATA) begin
                    len_d  = byte_data;
                    sum_d  = '0;
                    addr_d = '0;
                end
            end
            ST_DATA: begin
                if (byte_valid) begin
                    we_d    = 1'b1;
                    maddr_d = addr_q;
                    mdata_d = byte_data;
                    sum_d   = sum_q + byte_data;
                    // Address parks at LEN-1 after the final payload byte.
                    if (state_d == ST_DATA) addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_CSUM: begin
                if (state_d == ST_DONE) begin
                    done_d = 1'b1;
                    run_d  = 1'b1;
                end
            end
            default: ;
        endcase

        if (state_d == ST_ERR && state_q != ST_ERR) err_d = cause;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            to_q    <= '0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            mdata_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            len_q   <= len_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            to_q    <= to_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mem_we   = we_q;
        mem_addr = maddr_q;
        mem_data = mdata_q;
        cpu_run  = run_q;
        done     = done_q;
        err_code = err_q;
        busy     = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
        dbg.ldr  = state_q;
        dbg.rx   = rx_state;
    end

endmodule

// File: doc/prog_loader_uart.md
# prog_loader_uart

Serial program loader sitting directly upstream of the accumulator core's instruction memory. It receives a framed program image over a single UART RX line (8N1), writes each payload byte into instruction memory through a one-cycle write strobe, and releases the core to run only after the whole frame has arrived with a matching checksum. Until then, or after any error, `cpu_run` holds the core off.

## Interface
- `CLK_DIV`, 16: clock cycles per UART bit; minimum 4.
- `ADDR_W`, 5: instruction memory address width.
- `MAX_LEN`, 19: largest legal payload length in bytes (memory depth).
- `TIMEOUT`, 4096: idle clock cycles allowed between bytes inside a frame.
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  UART receive line, idle high, asynchronous to `clk`.
- `mem_we`  out  1  one-cycle instruction memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_data`  out  8  write data.
- `cpu_run`  out  1  high means the core may execute; low holds it.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse on a successful load.
- `err_code`  out  3  sticky status: 0 none, 1 bad length, 2 checksum, 3 timeout, 4 framing, 5 parity.

## Operation
- RX front end:
  - 2-flop synchronizer on `rx`.
  - A falling edge starts a frame; the start bit is re-checked at CLK_DIV/2. If it is high, treat the edge as a glitch and return to idle.
  - Data bits are sampled every CLK_DIV cycles, LSB first, then the stop bit.
  - A low stop bit is a framing error: discard the byte and report err 4.
  - `byte_valid` pulses for one cycle after a good stop bit.
- Frame format: SYNC (0xA5), LEN, LEN payload bytes, CSUM. CSUM is the sum of the payload mod 256.
- FSM states:
  - IDLE: non-SYNC bytes are ignored. SYNC goes to LEN, sets `busy`, clears `err_code`, drops `cpu_run`.
  - LEN: if 1 ≤ LEN ≤ MAX_LEN, store LEN, clear the sum, set the address to 0, and go to DATA. Otherwise go to ERR with code 1.
  - DATA: for each byte, issue a write to the current address, add the byte to the sum, and increment the address. After LEN bytes, go to CSUM.
  - CSUM: if the byte equals the sum, go to DONE (pulse `done`, set `cpu_run`). Otherwise go to ERR with code 2.
  - DONE and ERR: `busy` is 0. A received SYNC restarts at LEN. All other bytes are ignored.
- Timeout: in LEN, DATA and CSUM, the inter-byte counter resets on every `byte_valid`. Reaching TIMEOUT goes to ERR with code 3.
- A framing error inside a frame goes to ERR with code 4. In IDLE, DONE or ERR it only drops the byte.
- Payload bytes are already written when a checksum fails. `cpu_run`=0 is the only guard against running that image.
- Sum width is 8 bits and wraps. The address counter never exceeds LEN−1.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_data`=0, `cpu_run`=0, `busy`=0, `done`=0, `err_code`=0; FSM in IDLE; RX in idle.
- `byte_valid` is 1 cycle after the stop-bit sample. `mem_we`, `done`, and the ERR transition are registered 1 cycle after that, so 2 cycles after the stop sample.
- `mem_addr` and `mem_data` are stable in the `mem_we` cycle and hold afterwards.
- `cpu_run` falls in the cycle the SYNC byte is registered. This is the same cycle `busy` rises.
- Reset mid-frame: all outputs return to reset values immediately; any partial write sequence is abandoned.
- A byte that completes in the same cycle the timeout expires is taken as valid; the timeout loses.

## Configuration
- `PROG_LOADER_PARITY_EN` defined: the UART frame becomes 8E1 (even parity bit between data and stop). A parity mismatch discards the byte; inside a frame it goes to ERR with code 5.
- Undefined: 8N1, and code 5 is never produced.

## Structure
- `prog_loader_pkg`:
  - SYNC_BYTE constant.
  - FSM state enum.
  - `err_code` constants.
- One sub-module, `uart_rx_byte`: synchronizer, bit timing, optional parity, `byte_valid`/`byte_data`/`frame_err`/`parity_err`.

## Test plan
- CLK_DIV=16, send A5 03 01 05 0A 10:
  - writes (0,01), (1,05), (2,0A);
  - `done` pulses once, `cpu_run`=1, `err_code`=0.
- Same frame with CSUM 11:
  - three writes occur;
  - `cpu_run`=0, `err_code`=2, `busy`=0.
- Send A5 00, then A5 14:
  - no writes in either case;
  - `err_code`=1 each time.
- Send A5 02 07, then idle 4096 cycles: one write (0,07), then `err_code`=3.
- Assert `rst` after the second payload byte of a 5-byte frame: all outputs go to reset values. A subsequent full valid frame loads correctly from address 0.
- Stop bit forced low on the LEN byte gives `err_code`=4. With `PROG_LOADER_PARITY_EN`, a flipped parity bit on a payload byte gives `err_code`=5 and no write for that byte.
